// File: rtl/imm_arith_sequencer_pkg.sv
// Shared types and constants for the LEGv8 I-type arithmetic sequencer.
// Holds state encodings, control-word layout and opcode constants.
package imm_arith_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_EXEC   = 2'b01,
        S_WB     = 2'b10,
        S_UNUSED = 2'b11
    } state_e;

    localparam int CW_WIDTH = 29;

    localparam int CW_PSEL_OFF  = 27;
    localparam int CW_PSEL_W    = 2;
    localparam int CW_DA_OFF    = 22;
    localparam int CW_DA_W      = 5;
    localparam int CW_SA_OFF    = 17;
    localparam int CW_SA_W      = 5;
    localparam int CW_SB_OFF    = 12;
    localparam int CW_SB_W      = 5;
    localparam int CW_FSEL_OFF  = 7;
    localparam int CW_FSEL_W    = 5;
    localparam int CW_REGW_OFF  = 6;
    localparam int CW_RAMW_OFF  = 5;
    localparam int CW_DSEL_OFF  = 3;
    localparam int CW_DSEL_W    = 2;
    localparam int CW_BSEL_OFF  = 2;
    localparam int CW_PCSEL_OFF = 1;
    localparam int CW_SL_OFF    = 0;

    localparam logic [3:0] FSEL_ADD      = 4'b0100;
    localparam logic [1:0] DSEL_ALU      = 2'b01;
    localparam logic [1:0] PSEL_INC      = 2'b01;
    localparam logic [1:0] PSEL_HOLD     = 2'b00;
    localparam logic [5:0] OPC_IMM_ARITH = 6'b100010;

    typedef struct packed {
        logic [1:0] psel;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fsel;
        logic       regw;
        logic       ramw;
        logic [1:0] dsel;
        logic       bsel;
        logic       pcsel;
        logic       sl;
    } cw_t;

endpackage

// File: rtl/imm_arith_sequencer_cw_builder.sv
// Control-word builder for I-type arithmetic sequencing.
// Pure function of latched instruction, state and illegal flag.
module imm_arith_cw_builder
    import imm_arith_sequencer_pkg::*;
(
    input  logic [31:0]         instr_i,
    input  state_e              state_i,
    input  logic                illegal_i,
    output logic [CW_WIDTH-1:0] cw_o
);

    cw_t cw;

    // Fields this builder does not decode.
    logic unused_bits;
    assign unused_bits = ^{instr_i[31], instr_i[28:10]};

    // Map state to the datapath fields; illegal keeps only PC advance.
    always_comb begin
        cw = '0;
        case (state_i)
            S_EXEC: begin
                if (!illegal_i) begin
                    cw.psel = PSEL_HOLD;
                    cw.da   = instr_i[4:0];
                    cw.sa   = instr_i[9:5];
                    cw.fsel = {FSEL_ADD, instr_i[30]};
                    cw.dsel = DSEL_ALU;
                    cw.bsel = 1'b1;
                end
            end
            S_WB: begin
                cw.psel = PSEL_INC;
                if (!illegal_i) begin
                    cw.da   = instr_i[4:0];
                    cw.sa   = instr_i[9:5];
                    cw.fsel = {FSEL_ADD, instr_i[30]};
                    cw.dsel = DSEL_ALU;
                    cw.bsel = 1'b1;
                    cw.regw = 1'b1;
                    cw.sl   = instr_i[29];
                end
            end
            default: cw = '0;
        endcase
    end

    assign cw_o = cw;

endmodule

// File: rtl/imm_arith_sequencer.sv
// Multi-cycle sequencer for LEGv8 ADD/ADDS/SUB/SUBS immediate.
// Latches one instruction, walks IDLE-EXEC-WB, emits control words.
module imm_arith_sequencer
    import imm_arith_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int IMM_WIDTH      = 12,
    parameter int ENABLE_SHIFT12 = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [31:0]           instruction,
    input  logic                  stall,
    output logic [CW_WIDTH-1:0]   control_word,
    output logic [DATA_WIDTH-1:0] k_out,
    output logic [1:0]            state,
    output logic                  busy,
    output logic                  illegal
);

    state_e                state_q;
    logic [31:0]           instr_q;
    logic                  illegal_q;
    logic [DATA_WIDTH-1:0] k_q;

    logic                  legal_d;
    logic [DATA_WIDTH-1:0] k_ext;
    logic [DATA_WIDTH-1:0] k_d;

    // Decode legality and form K from the incoming word at accept.
    always_comb begin
        legal_d = (instruction[28:23] == OPC_IMM_ARITH) &&
                  (!instruction[22] || (ENABLE_SHIFT12 != 0));
        k_ext   = {{(DATA_WIDTH-IMM_WIDTH){1'b0}},
                   instruction[10 +: IMM_WIDTH]};
        k_d     = '0;
        if (legal_d)
            k_d = instruction[22] ? (k_ext << 12) : k_ext;
    end

    // Sequencer state, latched instruction, K and illegal flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            illegal_q <= 1'b0;
            k_q       <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q   <= instruction;
                        illegal_q <= !legal_d;
                        k_q       <= k_d;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC:   if (!stall) state_q <= S_WB;
                S_WB:     if (!stall) state_q <= S_IDLE;
                S_UNUSED: state_q <= S_IDLE;
            endcase
        end
    end

    imm_arith_cw_builder u_cw (
        .instr_i   (instr_q),
        .state_i   (state_q),
        .illegal_i (illegal_q),
        .cw_o      (control_word)
    );

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign state       = state_q;
    assign illegal     = illegal_q;
    assign k_out       = k_q;

endmodule

// File: tb/tb_imm_arith_sequencer.sv
// Scoreboard bench for imm_arith_sequencer.
// Two instances: shift12 enabled and disabled.
module tb_imm_arith_sequencer;

    typedef struct packed {
        logic [1:0]  st;
        logic [28:0] cw;
        logic [63:0] k;
        logic        ill;
        logic        rdy;
        logic        busy;
    } exp_t;

    localparam logic [31:0] ADDI = 32'h9100_1423;
    localparam logic [31:0] SUBS = 32'hF140_0482;
    localparam logic [31:0] MOVZ = 32'hD280_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        stall = 1'b0;

    logic [28:0] cw1, cw2;
    logic [63:0] k1, k2;
    logic [1:0]  st1, st2;
    logic        rdy1, rdy2, busy1, busy2, ill1, ill2;

    int compared = 0;
    int mismatched = 0;
    exp_t sb[$];

    always #5 clock = ~clock;

    imm_arith_sequencer #(.ENABLE_SHIFT12(1)) dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid),
        .instr_ready(rdy1), .instruction(instruction), .stall(stall),
        .control_word(cw1), .k_out(k1), .state(st1),
        .busy(busy1), .illegal(ill1)
    );

    imm_arith_sequencer #(.ENABLE_SHIFT12(0)) dut_ns (
        .clock(clock), .reset(reset), .instr_valid(instr_valid),
        .instr_ready(rdy2), .instruction(instruction), .stall(stall),
        .control_word(cw2), .k_out(k2), .state(st2),
        .busy(busy2), .illegal(ill2)
    );

    function automatic logic [28:0] mk_cw(
        input logic [1:0] psel, input logic [4:0] da, input logic [4:0] sa,
        input logic [4:0] fsel, input logic regw, input logic [1:0] dsel,
        input logic bsel, input logic sl);
        return {psel, da, sa, 5'd0, fsel, regw, 1'b0, dsel, bsel, 1'b0, sl};
    endfunction

    function automatic exp_t mk_exp(input logic [1:0] st,
        input logic [28:0] cw, input logic [63:0] k, input logic ill);
        exp_t e;
        e.st = st; e.cw = cw; e.k = k; e.ill = ill;
        e.rdy = (st == 2'b00); e.busy = (st != 2'b00);
        return e;
    endfunction

    task automatic test_reset();
        exp_t e, o;
        sb.push_back(mk_exp(2'b00, '0, '0, 1'b0));
        sb.push_back(mk_exp(2'b00, '0, '0, 1'b0));
        #12;
        o = {st1, cw1, k1, ill1, rdy1, busy1};
        e = sb.pop_front(); compared++;
        if (o !== e) begin
            mismatched++;
            $display("FAIL reset_hold got=%h want=%h", o, e);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        o = {st1, cw1, k1, ill1, rdy1, busy1};
        e = sb.pop_front(); compared++;
        if (o !== e) begin
            mismatched++;
            $display("FAIL reset_release got=%h want=%h", o, e);
        end
    endtask

    task automatic test_addi();
        exp_t e, o;
        sb.push_back(mk_exp(2'b01,
            mk_cw(2'b00, 5'd3, 5'd1, 5'b01000, 1'b0, 2'b01, 1'b1, 1'b0),
            64'd5, 1'b0));
        sb.push_back(mk_exp(2'b10,
            mk_cw(2'b01, 5'd3, 5'd1, 5'b01000, 1'b1, 2'b01, 1'b1, 1'b0),
            64'd5, 1'b0));
        sb.push_back(mk_exp(2'b00, '0, 64'd5, 1'b0));
        instruction = ADDI; instr_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            instr_valid = 1'b0;
            o = {st1, cw1, k1, ill1, rdy1, busy1};
            e = sb.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL addi c%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_shift12();
        exp_t e, o;
        sb.push_back(mk_exp(2'b01,
            mk_cw(2'b00, 5'd2, 5'd4, 5'b01001, 1'b0, 2'b01, 1'b1, 1'b0),
            64'h1000, 1'b0));
        sb.push_back(mk_exp(2'b01, '0, '0, 1'b1));
        sb.push_back(mk_exp(2'b10,
            mk_cw(2'b01, 5'd2, 5'd4, 5'b01001, 1'b1, 2'b01, 1'b1, 1'b1),
            64'h1000, 1'b0));
        sb.push_back(mk_exp(2'b10, {2'b01, 27'd0}, '0, 1'b1));
        sb.push_back(mk_exp(2'b00, '0, 64'h1000, 1'b0));
        sb.push_back(mk_exp(2'b00, '0, '0, 1'b1));
        instruction = SUBS; instr_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            instr_valid = 1'b0;
            o = {st1, cw1, k1, ill1, rdy1, busy1};
            e = sb.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL subs_sh c%0d got=%h want=%h", c, o, e);
            end
            o = {st2, cw2, k2, ill2, rdy2, busy2};
            e = sb.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL subs_nosh c%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_illegal();
        exp_t e, o;
        sb.push_back(mk_exp(2'b01, '0, '0, 1'b1));
        sb.push_back(mk_exp(2'b10, {2'b01, 27'd0}, '0, 1'b1));
        sb.push_back(mk_exp(2'b00, '0, '0, 1'b1));
        instruction = MOVZ; instr_valid = 1'b1; stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            instr_valid = 1'b0; stall = 1'b0;
            o = {st1, cw1, k1, ill1, rdy1, busy1};
            e = sb.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL illegal c%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    task automatic test_stall();
        exp_t e, o;
        logic [7:0] stall_after;
        stall_after = 8'b0011_0111;
        for (int c = 0; c < 8; c++) begin
            if (c < 4)
                sb.push_back(mk_exp(2'b01,
                    mk_cw(2'b00, 5'd3, 5'd1, 5'b01000, 1'b0, 2'b01, 1'b1, 1'b0),
                    64'd5, 1'b0));
            else if (c < 7)
                sb.push_back(mk_exp(2'b10,
                    mk_cw(2'b01, 5'd3, 5'd1, 5'b01000, 1'b1, 2'b01, 1'b1, 1'b0),
                    64'd5, 1'b0));
            else
                sb.push_back(mk_exp(2'b00, '0, 64'd5, 1'b0));
        end
        instruction = ADDI; instr_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            instr_valid = 1'b0;
            stall = stall_after[c];
            o = {st1, cw1, k1, ill1, rdy1, busy1};
            e = sb.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL stall c%0d got=%h want=%h", c, o, e);
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        sb.push_back(mk_exp(2'b01,
            mk_cw(2'b00, 5'd3, 5'd1, 5'b01000, 1'b0, 2'b01, 1'b1, 1'b0),
            64'd5, 1'b0));
        sb.push_back(mk_exp(2'b10,
            mk_cw(2'b01, 5'd3, 5'd1, 5'b01000, 1'b1, 2'b01, 1'b1, 1'b0),
            64'd5, 1'b0));
        sb.push_back(mk_exp(2'b00, '0, 64'd5, 1'b0));
        sb.push_back(mk_exp(2'b01,
            mk_cw(2'b00, 5'd2, 5'd4, 5'b01001, 1'b0, 2'b01, 1'b1, 1'b0),
            64'h1000, 1'b0));
        sb.push_back(mk_exp(2'b10,
            mk_cw(2'b01, 5'd2, 5'd4, 5'b01001, 1'b1, 2'b01, 1'b1, 1'b1),
            64'h1000, 1'b0));
        sb.push_back(mk_exp(2'b00, '0, 64'h1000, 1'b0));
        instruction = ADDI; instr_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            instruction = SUBS;
            if (c == 3) instr_valid = 1'b0;
            o = {st1, cw1, k1, ill1, rdy1, busy1};
            e = sb.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL b2b c%0d got=%h want=%h", c, o, e);
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wb();
        exp_t e, o;
        sb.push_back(mk_exp(2'b10,
            mk_cw(2'b01, 5'd3, 5'd1, 5'b01000, 1'b1, 2'b01, 1'b1, 1'b0),
            64'd5, 1'b0));
        sb.push_back(mk_exp(2'b00, '0, '0, 1'b0));
        for (int c = 0; c < 3; c++)
            sb.push_back(mk_exp(2'b00, '0, '0, 1'b0));
        instruction = ADDI; instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        @(posedge clock); #1;
        o = {st1, cw1, k1, ill1, rdy1, busy1};
        e = sb.pop_front(); compared++;
        if (o !== e) begin
            mismatched++;
            $display("FAIL rst_pre_wb got=%h want=%h", o, e);
        end
        #2 reset = 1'b0;
        #1;
        o = {st1, cw1, k1, ill1, rdy1, busy1};
        e = sb.pop_front(); compared++;
        if (o !== e) begin
            mismatched++;
            $display("FAIL rst_async got=%h want=%h", o, e);
        end
        #3 reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            o = {st1, cw1, k1, ill1, rdy1, busy1};
            e = sb.pop_front(); compared++;
            if (o !== e) begin
                mismatched++;
                $display("FAIL rst_after c%0d got=%h want=%h", c, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_shift12();
        test_illegal();
        test_addi();
        test_stall();
        test_back_to_back();
        test_reset_mid_wb();
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imm_arith_sequencer.md
Name: imm_arith_sequencer

Overview:
Multi-cycle control sequencer for ADD/ADDS/SUB/SUBS immediate instructions in the LEGv8 multicycle datapath. It is the registered, parametrised successor of the combinational I-arithmetic decoder.
- Accepts an instruction through a valid/ready handshake and latches it.
- Walks an internal state machine and emits one 29-bit control word per cycle.
- Produces the extended, optionally shifted immediate K for the datapath.
- Flags illegal encodings.

Parameters:
DATA_WIDTH, 64, width of k_out (datapath word).
IMM_WIDTH, 12, immediate field width, taken from instruction[10 +: IMM_WIDTH]; must be 12 for LEGv8.
ENABLE_SHIFT12, 1, when 1, sh bit (instruction[22]) shifts K left by 12; when 0, sh=1 is illegal.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instr_valid  in  1  fetch presents a valid instruction
instr_ready  out  1  sequencer can accept (IDLE only)
instruction  in  32  instruction word, sampled on accept
stall  in  1  hold current state and control word (hazard/memory wait)
control_word  out  29  {Psel[1:0],DA[4:0],SA[4:0],SB[4:0],Fsel[4:0],regW,ramW,Dsel[1:0],Bsel,PCsel,SL}
k_out  out  DATA_WIDTH  zero-extended immediate, shifted if sh=1
state  out  2  current state encoding
busy  out  1  state != IDLE
illegal  out  1  latched illegal-encoding flag

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; instruction register=0; illegal=0.
  - control_word=0; k_out=0; instr_ready=1 once reset released.
- States: IDLE=2'b00, EXEC=2'b01, WB=2'b10; 2'b11 is unused and returns to IDLE next cycle with control_word=0.
- IDLE:
  - instr_ready=1, control_word=0.
  - On instr_valid=1: latch instruction, go to EXEC; stall is ignored in IDLE.
  - Decode at accept: legal iff instruction[28:23]==6'b100010 and (instruction[22]==0 or ENABLE_SHIFT12==1).
  - illegal is registered at accept: set if the encoding is illegal, cleared if legal.
- EXEC (legal):
  - Psel=00, DA=instr[4:0], SA=instr[9:5], SB=0.
  - Fsel={4'b0100,instr[30]}, regW=0, ramW=0, Dsel=01, Bsel=1, PCsel=0, SL=0.
  - Go to WB unless stall=1, which holds EXEC with identical outputs.
- WB (legal):
  - Same fields as EXEC, except regW=1, SL=instr[29], Psel=01.
  - Go to IDLE unless stall=1, which holds WB.
  - Each held WB cycle re-asserts regW; the datapath must tolerate repeated identical writes.
- Illegal instruction:
  - EXEC emits control_word=0.
  - WB emits only Psel=01 (PC advances past the instruction); all other fields are 0.
  - illegal stays 1 until the next accept.
- Latency: accept edge to WB is 2 cycles; minimum issue interval is 3 cycles (IDLE, EXEC, WB).
- k_out:
  - Registered at accept: zero-extend instr[21:10] to DATA_WIDTH; shift left 12 if sh=1 (bits above DATA_WIDTH are discarded).
  - Constant through EXEC/WB; 0 after an illegal accept.
- All outputs are driven from registers or from state plus the latched instruction; there is no combinational path from instruction to control_word.
- Reset asserted mid-EXEC/WB aborts immediately; no regW pulse or PC increment is emitted afterwards.
- instr_valid held high while busy has no effect; the instruction is not consumed.

Decomposition:
- Shared package holds:
  - state encodings (S_IDLE, S_EXEC, S_WB);
  - control-word field offsets and widths, CW_WIDTH=29;
  - constants FSEL_ADD=4'b0100, DSEL_ALU=2'b01, PSEL_INC=2'b01, PSEL_HOLD=2'b00, OPC_IMM_ARITH=6'b100010.
- One natural sub-module, imm_arith_cw_builder: combinational; latched instruction + state + illegal -> control_word. Reused by future I-type sequencers.

Test Plan:
- ADDI X3,X1,#5 (0x91001423), no stall -> EXEC CW regW=0 Psel=00 Fsel=01000 Bsel=1; WB CW regW=1 Psel=01 SL=0 DA=3 SA=1; k_out=5; IDLE after 3 cycles.
- SUBS X2,X4,#1,LSL#12 (0xF1400482), ENABLE_SHIFT12=1 -> Fsel=01001, SL=1 in WB, k_out=0x1000.
- Same SUBS with ENABLE_SHIFT12=0 -> illegal=1, EXEC CW=0, WB CW=Psel=01 only, k_out=0.
- ADDI with stall=1 for 3 cycles in EXEC then 2 in WB -> outputs held constant, state 01 then 10, IDLE reached 5 cycles later than no-stall.
- reset driven low mid-WB -> control_word=0, state=00 asynchronously; after release, instr_ready=1 and no regW pulse.
- Back-to-back instr_valid=1 held -> second instruction accepted only in IDLE, exactly 3 cycles after the first accept.
